rr_arbiter_8_enc: RTL
=====================

// Module: rr_arbiter_8_enc
//
// PURPOSE
//   Eight-requester round-robin arbiter with a binary-encoded grant index.
//   Sits directly upstream of decoder_3_8: idx drives the decoder input I.
//   The one-hot grant is formed downstream as Q & {8{idx_valid}}.
//   Grants are held until the owner signals done, drops its request, or the hold timer expires.
//
// PARAMETERS
//   MAX_HOLD  16  maximum grant length in cycles (>=2); forced release when reached
//
// PORTS
//   clk        in   1  system clock; all state changes on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  request vector; bit k = requester k
//   done       in   1  current owner releases grant (sampled only in GRANT)
//   idx        out  3  encoded index of granted requester; feeds decoder_3_8 I
//   idx_valid  out  1  idx is a live grant
//   timeout    out  1  one-cycle pulse: grant forcibly ended by hold timer
//   busy       out  1  high in GRANT state (equals idx_valid)
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): idx=0, idx_valid=0, timeout=0, busy=0, state=IDLE,
//     last-grant pointer=7 (first priority is requester 0), hold counter=0.
//   - States: IDLE, GRANT. All outputs are registered.
//   - IDLE: if req!=0, search from (last+1) mod 8 upward with wrap for the first set bit.
//     Next edge: idx=winner, idx_valid=1, busy=1, hold counter=1, state=GRANT.
//     Latency from req sampled to idx_valid high = 1 cycle. If req==0, stay in IDLE with outputs unchanged.
//   - GRANT: idx is stable for the whole grant. The counter increments each cycle.
//     The grant ends at an edge where any of the following holds:
//     (a) done=1; (b) req[idx]=0; (c) counter==MAX_HOLD.
//     On end: idx_valid=0, busy=0, last=idx, state=IDLE.
//     timeout=1 for that one cycle only if (c) holds and neither (a) nor (b) holds.
//   - Gap: after every grant, idx_valid stays low for at least 1 cycle.
//     A new grant is re-arbitrated in IDLE; back-to-back grants are never merged.
//   - idx retains its last granted value while idx_valid=0. It is only meaningful with idx_valid.
//   - Fairness: the requester just served has lowest priority next round.
//     With all 8 requesting continuously, grants cycle 0,1,...,7,0.
//   - Simultaneous events: done and timeout together means done wins (timeout=0).
//     Requests changing during GRANT are ignored until IDLE.
//   - Counter width: $clog2(MAX_HOLD+1). It saturates at MAX_HOLD and never wraps.
//   - Reset mid-grant: immediate async return to reset values. The pointer returns to 7.
//
// TESTING
//   1. Reset with req=8'hFF: idx_valid=0 during reset; 1 cycle after release, idx=0, idx_valid=1.
//   2. req=8'hFF held, done pulsed 1 cycle per grant: idx sequence 0,1,2,...,7,0.
//      Each grant is separated by exactly 1 idle cycle.
//   3. req=8'b0010_0100, last=2 after a grant to 2: next grant idx=5, then idx=2 (wrap).
//   4. req[3] only, done never asserted: idx=3 valid for exactly 16 cycles.
//      Then timeout=1 for one cycle, idx_valid=0, then re-grant to 3.
//   5. Grant to 6, deassert req[6] mid-grant: idx_valid falls next edge, timeout=0.
//      Assert done and counter==MAX_HOLD together: timeout=0.
//   6. Drive rst_n=0 asynchronously mid-grant (between clock edges): outputs clear immediately.
//      After release with req=8'h80: grant idx=7.
//      Check decoder_3_8 Q & {8{idx_valid}}=8'h80.

Source files
------------

// File: rtl/rr_arbiter_8_enc.sv
// Eight-requester round-robin arbiter with a binary-encoded grant index.
// A grant is held until done, until the owner drops its request, or until the hold timer expires.
module rr_arbiter_8_enc #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] idx,
  output logic       idx_valid,
  output logic       timeout,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [2:0]    last;
  logic [CW-1:0] hold_cnt;
  logic [2:0]    winner;
  logic [2:0]    cand;
  logic          found;
  logic          at_max;
  logic          end_grant;

  // Search from the requester after the last one served, wrapping through all eight.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign at_max    = (hold_cnt == CW'(MAX_HOLD));
  assign end_grant = done | ~req[idx] | at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 3'd7;
      hold_cnt  <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            idx       <= winner;
            idx_valid <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= CW'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (end_grant) begin
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            last      <= idx;
            state     <= IDLE;
            // A voluntary release on the same edge takes precedence over the timer.
            timeout   <= at_max & ~done & req[idx];
          end else if (!at_max) begin
            hold_cnt  <= hold_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
